// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
// Divisor constants assume the 100 MHz board clock.
package clkdiv_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DIV_1KHZ    = 100_000;
    localparam int unsigned DIV_100HZ   = 1_000_000;
    localparam int unsigned DIV_10HZ    = 10_000_000;
    localparam int unsigned DIV_1HZ     = 100_000_000;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: free-running counter with a 1-cycle tick and a square enable.
// A newly written divisor waits in pend_div until the current period ends.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int          DIV_W   = 27,
    parameter int unsigned DEF_DIV = DIV_1KHZ
)(
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend,
    output logic             tick,
    output logic             clk
);

    localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_act_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_tick;
    logic             r_clk;

    logic             w_run;
    logic             w_wrap;
    logic             w_apply;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_cnt_inc;

    // D-1 is only meaningful while running, so the wrap compare is gated by w_run.
    assign w_run     = en && (r_act_div != '0);
    assign w_wrap    = w_run && (r_cnt == (r_act_div - ONE));
    assign w_apply   = r_pend && (sync || !w_run || w_wrap);
    assign w_half    = (r_act_div >> 1) + {{(DIV_W-1){1'b0}}, r_act_div[0]};
    assign w_cnt_inc = r_cnt + ONE;

    // Staged divisor carries no reset: it is only consumed while r_pend is set.
    always_ff @(posedge clk_in) begin
        if (wr) begin
            r_pend_div <= wr_div;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_act_div <= DEF_D;
            r_pend    <= 1'b0;
            r_tick    <= 1'b0;
            r_clk     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_div <= r_pend_div;
            end
            // A write on an apply edge re-arms pending with the newly written value.
            if (wr) begin
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end

            if (sync || !w_run) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_clk  <= 1'b0;
            end else if (w_wrap) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_clk  <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_tick <= 1'b0;
                r_clk  <= r_clk && (w_cnt_inc < w_half);
            end
        end
    end

    assign pend = r_pend;
    assign tick = r_tick;
    assign clk  = r_clk;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel clock-enable generator with a shared configuration port and global sync.
// Writes addressed beyond the last channel match no decoder line and are dropped.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          DIV_W   = 27,
    parameter int unsigned DEF_DIV = DIV_1KHZ,
    localparam int         CH_W    = clog2((NUM_CH > 2) ? NUM_CH : 2)
)(
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_o
);

    logic [NUM_CH-1:0] w_wr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_wr[gi] = cfg_we && (cfg_ch == CH_W'(gi));

        clkdiv_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_in (clk_in),
            .rst    (rst),
            .en     (en_i[gi]),
            .sync   (sync_i),
            .wr     (w_wr[gi]),
            .wr_div (cfg_div),
            .pend   (cfg_pend[gi]),
            .tick   (tick_o[gi]),
            .clk    (clk_o[gi])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomised and directed bench for multi_clock_divider against a cycle-level reference model.
module tb_multi_clock_divider;

    localparam int NUM_CH  = 5;
    localparam int DIV_W   = 27;
    localparam int DEF_DIV = 4;
    localparam int CH_W    = 3;

    logic              clk_in = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en_i;
    logic              sync_i;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] cfg_pend;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] clk_o;

    int n_chk  = 0;
    int n_fail = 0;
    int rel    = 0;
    bit chk_on = 1'b0;

    // Reference model: position within the current period, active/pending divisor,
    // and whether the channel has completed a period since its last restart.
    int unsigned m_cnt   [NUM_CH];
    int unsigned m_d     [NUM_CH];
    int unsigned m_pdiv  [NUM_CH];
    bit          m_pend  [NUM_CH];
    bit          m_start [NUM_CH];

    multi_clock_divider #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en_i     (en_i),
        .sync_i   (sync_i),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_pend (cfg_pend),
        .tick_o   (tick_o),
        .clk_o    (clk_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d, t=%0t)", nm, act, exp, rel, $time);
        end
    endtask

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[i]   = 0;
                m_d[i]     = DEF_DIV;
                m_pend[i]  = 1'b0;
                m_start[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                bit restart, wrap, apply;
                restart = sync_i || !en_i[i] || (m_d[i] == 0);
                wrap    = !restart && (m_cnt[i] + 1 == m_d[i]);
                apply   = m_pend[i] && (restart || wrap);
                if (restart) begin
                    m_cnt[i]   = 0;
                    m_start[i] = 1'b0;
                end else if (wrap) begin
                    m_cnt[i]   = 0;
                    m_start[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
                if (apply) begin
                    m_d[i]    = m_pdiv[i];
                    m_pend[i] = 1'b0;
                end
                if (cfg_we && (int'(cfg_ch) == i)) begin
                    m_pdiv[i] = cfg_div;
                    m_pend[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            logic [NUM_CH-1:0] e_tick, e_clk, e_pend;
            for (int i = 0; i < NUM_CH; i++) begin
                e_tick[i] = m_start[i] && (m_cnt[i] == 0);
                e_clk[i]  = e_tick[i] || (m_start[i] && (m_cnt[i] < (m_d[i] + 1) / 2));
                e_pend[i] = m_pend[i];
            end
            check("model_tick", 32'(tick_o), 32'(e_tick));
            check("model_clk", 32'(clk_o), 32'(e_clk));
            check("model_pend", 32'(cfg_pend), 32'(e_pend));
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk_in);
            rel++;
        end
    endtask

    task automatic until_cyc(input int n);
        while (rel < n) adv(1);
    endtask

    task automatic set_wr(input int ch, input int d);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(d);
    endtask

    initial begin
        rst     = 1'b0;
        en_i    = '0;
        sync_i  = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
        #1 rst  = 1'b1;
        repeat (2) @(negedge clk_in);
        chk_on = 1'b1;
        check("reset_tick", 32'(tick_o), 32'h0);
        check("reset_clk", 32'(clk_o), 32'h0);
        check("reset_pend", 32'(cfg_pend), 32'h0);
        rst  = 1'b0;
        en_i = '1;
        rel  = 0;

        // Default divisor 4 from cnt=0 at cycle 0.
        until_cyc(3);  check("d4_tick_c3", 32'(tick_o), 32'h00);
        until_cyc(4);  check("d4_tick_c4", 32'(tick_o), 32'h1f);
        check("d4_clk_c4", 32'(clk_o), 32'h1f);
        until_cyc(5);  check("d4_clk_c5", 32'(clk_o[0]), 32'h1);
        until_cyc(6);  check("d4_clk_c6", 32'(clk_o[0]), 32'h0);
        until_cyc(7);  check("d4_clk_c7", 32'(clk_o[0]), 32'h0);
        until_cyc(8);  check("d4_tick_c8", 32'(tick_o[0]), 32'h1);
        until_cyc(12); check("d4_tick_c12", 32'(tick_o[0]), 32'h1);

        // Divisors 1, 2, 3 on ch0..ch2, phase-aligned by sync.
        set_wr(0, 1); adv(1);
        set_wr(1, 2); adv(1);
        set_wr(2, 3); adv(1);
        cfg_we = 1'b0; sync_i = 1'b1; adv(1);
        sync_i = 1'b0; rel = 0;
        until_cyc(4);
        check("d1_tick_c4", 32'(tick_o[0]), 32'h1);
        check("d2_clk_c4", 32'(clk_o[1]), 32'h1);
        check("d3_clk_c4", 32'(clk_o[2]), 32'h1);
        until_cyc(5);
        check("d1_clk_c5", 32'(clk_o[0]), 32'h1);
        check("d2_clk_c5", 32'(clk_o[1]), 32'h0);
        check("d3_clk_c5", 32'(clk_o[2]), 32'h0);
        until_cyc(6);
        check("d3_tick_c6", 32'(tick_o[2]), 32'h1);
        check("d2_clk_c6", 32'(clk_o[1]), 32'h1);

        // ch0 D=10 aligned at cycle 0, D=5 written in cycle 3.
        set_wr(0, 10); adv(1);
        cfg_we = 1'b0; sync_i = 1'b1; adv(1);
        sync_i = 1'b0; rel = 0;
        until_cyc(3); set_wr(0, 5); adv(1);
        cfg_we = 1'b0;
        check("pend_c4", 32'(cfg_pend[0]), 32'h1);
        until_cyc(9);  check("pend_c9", 32'(cfg_pend[0]), 32'h1);
        check("d10_tick_c9", 32'(tick_o[0]), 32'h0);
        until_cyc(10); check("d10_tick_c10", 32'(tick_o[0]), 32'h1);
        until_cyc(11); check("pend_c11", 32'(cfg_pend[0]), 32'h0);
        until_cyc(15); check("d5_tick_c15", 32'(tick_o[0]), 32'h1);
        until_cyc(20); check("d5_tick_c20", 32'(tick_o[0]), 32'h1);

        // Write on the wrap edge, then 7 and 6 before the next wrap: only 6 takes effect.
        until_cyc(24); set_wr(0, 9); adv(1);
        cfg_we = 1'b0;
        check("wrapwr_tick_c25", 32'(tick_o[0]), 32'h1);
        check("wrapwr_pend_c25", 32'(cfg_pend[0]), 32'h1);
        until_cyc(26); set_wr(0, 7); adv(1);
        set_wr(0, 6); adv(1);
        cfg_we = 1'b0;
        until_cyc(30); check("last_tick_c30", 32'(tick_o[0]), 32'h1);
        until_cyc(31); check("last_pend_c31", 32'(cfg_pend[0]), 32'h0);
        until_cyc(35); check("d6_tick_c35", 32'(tick_o[0]), 32'h0);
        until_cyc(36); check("d6_tick_c36", 32'(tick_o[0]), 32'h1);
        until_cyc(37); check("d6_tick_c37", 32'(tick_o[0]), 32'h0);
        until_cyc(42); check("d6_tick_c42", 32'(tick_o[0]), 32'h1);

        // Sync realignment, out-of-range write, parked channel.
        set_wr(0, 3); adv(1);
        set_wr(1, 5); adv(1);
        set_wr(3, 0); adv(1);
        cfg_we = 1'b0; sync_i = 1'b1; adv(1);
        sync_i = 1'b0; rel = 0;
        until_cyc(16);
        sync_i = 1'b1; set_wr(NUM_CH, 2); adv(1);
        sync_i = 1'b0; cfg_we = 1'b0;
        check("sync_tick_c17", 32'(tick_o), 32'h0);
        check("sync_clk_c17", 32'(clk_o), 32'h0);
        until_cyc(18);
        check("sync_tick_c18", 32'(tick_o), 32'h0);
        check("sync_clk_c18", 32'(clk_o), 32'h0);
        check("oor_pend_c18", 32'(cfg_pend), 32'h0);
        until_cyc(20); check("d3_tick_c20", 32'(tick_o[0]), 32'h1);
        until_cyc(22);
        check("d5_tick_c22", 32'(tick_o[1]), 32'h1);
        check("park_tick_c22", 32'(tick_o[3]), 32'h0);
        check("park_clk_c22", 32'(clk_o[3]), 32'h0);
        set_wr(4, 9); adv(1);
        cfg_we = 1'b0;
        check("pre_rst_clk1", 32'(clk_o[1]), 32'h1);
        check("pre_rst_pend4", 32'(cfg_pend[4]), 32'h1);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("arst_tick", 32'(tick_o), 32'h0);
        check("arst_clk", 32'(clk_o), 32'h0);
        check("arst_pend", 32'(cfg_pend), 32'h0);
        @(negedge clk_in);
        rst = 1'b0; rel = 0;
        until_cyc(3); check("post_rst_tick_c3", 32'(tick_o), 32'h00);
        until_cyc(4); check("post_rst_tick_c4", 32'(tick_o), 32'h1f);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NUM_CH; i++) en_i[i] = ($urandom_range(0, 9) != 0);
            sync_i = ($urandom_range(0, 49) == 0);
            cfg_we = ($urandom_range(0, 6) == 0);
            cfg_ch = CH_W'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) cfg_div = DIV_W'($urandom_range(0, 3));
            else                          cfg_div = DIV_W'($urandom_range(1, 12));
            adv(1);
        end
        en_i = '1; sync_i = 1'b0; cfg_we = 1'b0;
        adv(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
